pc_control: RTL and testbench

PC_CONTROL -- requirements
Module: pc_control

---
 rtl/pc_control.sv | 95 +++++++++
 tb/tb_pc_control.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_control.sv
// Program-counter and condition-flag control for a 16-bit core.
// Selects the next pc (sequential, relative branch or register branch), keeps the
// {Z,N,V} flags, and stops fetching permanently on HLT until the next reset.
module pc_control #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [15:0] instr,
  input  logic [2:0]  alu_flags,
  input  logic [15:0] rs_data,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic [2:0]  flags,
  output logic        branch_taken,
  output logic        hlt
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_ROR = 4'b0110;
  localparam logic [3:0] OP_B   = 4'b1100;
  localparam logic [3:0] OP_BR  = 4'b1101;
  localparam logic [3:0] OP_HLT = 4'b1111;

  typedef enum logic {RUN, HALTED} state_t;
  state_t state;

  logic [3:0]         opcode;
  logic [2:0]         ccc;
  logic [8:0]         imm9;
  logic signed [15:0] b_offset;
  logic [15:0]        b_target;
  logic [15:0]        next_target;
  logic               flag_z, flag_n, flag_v;
  logic               cond_met;

  assign opcode   = instr[15:12];
  assign ccc      = instr[11:9];
  assign imm9     = instr[8:0];
  assign flag_z   = flags[2];
  assign flag_n   = flags[1];
  assign flag_v   = flags[0];

  // Sequential address and the relative-branch target; both wrap modulo 2^16.
  assign pc_plus2    = pc + 16'd2;
  assign b_offset    = {{6{imm9[8]}}, imm9, 1'b0};
  assign b_target    = pc_plus2 + b_offset;
  assign next_target = (opcode == OP_BR) ? rs_data : b_target;

  // Condition decode against the flags held before this instruction's edge.
  always_comb begin
    cond_met = 1'b0;
    case (ccc)
      3'b000: cond_met = ~flag_z;
      3'b001: cond_met = flag_z;
      3'b010: cond_met = ~flag_z & ~flag_n;
      3'b011: cond_met = flag_n;
      3'b100: cond_met = flag_z | (~flag_z & ~flag_n);
      3'b101: cond_met = flag_n | flag_z;
      3'b110: cond_met = flag_v;
      default: cond_met = 1'b1;
    endcase
  end

  // Branches resolve only while running; stall does not mask the decode.
  assign branch_taken = (state == RUN) && ((opcode == OP_B) || (opcode == OP_BR)) && cond_met;

  // RUN/HALTED machine owning pc, flags and the halt indicator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      flags <= 3'b000;
      hlt   <= 1'b0;
    end else if ((state == RUN) && !stall) begin
      if (opcode == OP_HLT) begin
        state <= HALTED;
        hlt   <= 1'b1;
      end else begin
        pc <= branch_taken ? next_target : pc_plus2;
        case (opcode)
          OP_ADD, OP_SUB:                 flags    <= alu_flags;
          OP_XOR, OP_SLL, OP_SRA, OP_ROR: flags[2] <= alu_flags[2];
          default:                        flags    <= flags;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_control.sv
// Directed bench for pc_control with an integer-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_pc_control;

  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [15:0] instr, rs_data;
  logic [2:0]  alu_flags;
  logic [15:0] pc, pc_plus2;
  logic [2:0]  flags;
  logic        branch_taken, hlt;

  int n_checks = 0;
  int n_fail   = 0;

  int          m_pc     = 0;
  logic [2:0]  m_flags  = 3'b000;
  bit          m_halted = 1'b0;
  bit          m_valid  = 1'b0;

  pc_control #(.RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .instr(instr), .alu_flags(alu_flags),
    .rs_data(rs_data), .pc(pc), .pc_plus2(pc_plus2), .flags(flags),
    .branch_taken(branch_taken), .hlt(hlt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: does the current instruction branch, given flags and run state.
  function automatic bit m_taken(input logic [15:0] i, input logic [2:0] f, input bit halted);
    bit z, n, v;
    int op, c;
    op = int'(i[15:12]);
    c  = int'(i[11:9]);
    z = f[2]; n = f[1]; v = f[0];
    if (halted || (op != 12 && op != 13)) return 1'b0;
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || (!z && !n);
      5: return n || z;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int m_target(input logic [15:0] i, input int p, input logic [15:0] rs);
    int simm;
    if (i[15:12] == 4'hD) return int'(rs);
    simm = int'(i[8:0]);
    if (simm >= 256) simm = simm - 512;
    return ((p + 2 + 2 * simm) % 65536 + 65536) % 65536;
  endfunction

  function automatic logic [2:0] m_next_flags(input logic [15:0] i, input logic [2:0] f,
                                              input logic [2:0] a);
    int op;
    op = int'(i[15:12]);
    if (op == 0 || op == 1) return a;
    if (op == 2 || op == 4 || op == 5 || op == 6) return {a[2], f[1], f[0]};
    return f;
  endfunction

  // Reference model advanced on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_pc     <= int'(RESET_PC);
      m_flags  <= 3'b000;
      m_halted <= 1'b0;
      m_valid  <= 1'b1;
    end else if (m_valid && !m_halted && !stall) begin
      if (instr[15:12] == 4'hF) begin
        m_halted <= 1'b1;
      end else begin
        m_pc    <= m_taken(instr, m_flags, m_halted) ? m_target(instr, m_pc, rs_data)
                                                     : (m_pc + 2) % 65536;
        m_flags <= m_next_flags(instr, m_flags, alu_flags);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc", pc, 16'(m_pc));
      check("pc_plus2", pc_plus2, 16'((m_pc + 2) % 65536));
      check("flags", {13'b0, flags}, {13'b0, m_flags});
      check("hlt", {15'b0, hlt}, {15'b0, m_halted});
      check("branch_taken", {15'b0, branch_taken},
            {15'b0, m_taken(instr, m_flags, m_halted)});
    end
  end

  task automatic apply(input logic r, input logic s, input logic [15:0] i,
                       input logic [2:0] a, input logic [15:0] rs);
    rst = r; stall = s; instr = i; alu_flags = a; rs_data = rs;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [15:0] i, input logic [2:0] a, input logic [15:0] rs);
    apply(1'b0, 1'b0, i, a, rs);
    tick();
  endtask

  task automatic jump(input logic [15:0] addr);
    run(16'hDE00, 3'b000, addr);
  endtask

  initial begin
    logic [15:0] ins;

    apply(1'b1, 1'b0, 16'h3000, 3'b000, 16'h0000);
    tick();
    check("reset_pc", pc, 16'h0000);
    check("reset_flags", {13'b0, flags}, 16'h0000);
    check("reset_hlt", {15'b0, hlt}, 16'h0000);

    // Straight-line fetch.
    run(16'h3000, 3'b000, 16'h0);  check("seq_pc1", pc, 16'h0002);
    run(16'h3000, 3'b000, 16'h0);  check("seq_pc2", pc, 16'h0004);
    run(16'h3000, 3'b000, 16'h0);  check("seq_pc3", pc, 16'h0006);
    check("seq_hlt", {15'b0, hlt}, 16'h0000);
    check("seq_flags", {13'b0, flags}, 16'h0000);

    // SUB sets Z, backward branch on Z taken.
    jump(16'h0010);                check("br_to_10", pc, 16'h0010);
    run(16'h1000, 3'b100, 16'h0);
    check("sub_flags", {13'b0, flags}, 16'h0004);
    check("sub_pc", pc, 16'h0012);
    apply(1'b0, 1'b0, 16'hC3FC, 3'b000, 16'h0);
    #1 check("b_taken", {15'b0, branch_taken}, 16'h0001);
    tick();                        check("b_target", pc, 16'h000C);

    // XOR clears Z only; same branch now falls through.
    jump(16'h0020);
    run(16'h2000, 3'b011, 16'h0);
    check("xor_flags", {13'b0, flags}, 16'h0000);
    check("xor_pc", pc, 16'h0022);
    apply(1'b0, 1'b0, 16'hC3FC, 3'b000, 16'h0);
    #1 check("b_not_taken", {15'b0, branch_taken}, 16'h0000);
    tick();                        check("b_fallthru", pc, 16'h0024);

    // Register branch.
    apply(1'b0, 1'b0, 16'hDE00, 3'b000, 16'hABCE);
    #1 check("br_taken", {15'b0, branch_taken}, 16'h0001);
    tick();                        check("br_pc", pc, 16'hABCE);

    // Address wrap.
    jump(16'hFFFE);
    apply(1'b0, 1'b0, 16'h3000, 3'b000, 16'h0);
    #1 check("wrap_plus2", pc_plus2, 16'h0000);
    tick();                        check("wrap_pc", pc, 16'h0000);

    // PCS write-back value.
    apply(1'b0, 1'b0, 16'hE000, 3'b000, 16'h0);
    #1 check("pcs_plus2", pc_plus2, 16'h0002);
    tick();                        check("pcs_pc", pc, 16'h0002);

    // Every condition code against every flag combination.
    for (int f = 0; f < 8; f++) begin
      run(16'h0000, 3'(f), 16'h0);
      for (int c = 0; c < 8; c++) begin
        ins = {4'hC, 3'(c), 9'h002};
        run(ins, 3'(f), 16'h0);
      end
    end
    run(16'h0000, 3'b010, 16'h0);
    apply(1'b0, 1'b0, 16'hC802, 3'b000, 16'h0);
    #1 check("ccc100_n_set", {15'b0, branch_taken}, 16'h0000);
    tick();

    // HLT under stall is deferred, then halts and freezes.
    jump(16'h0030);
    apply(1'b0, 1'b1, 16'hF000, 3'b000, 16'h0);
    tick(); tick();
    check("hlt_stalled", {15'b0, hlt}, 16'h0000);
    check("hlt_stalled_pc", pc, 16'h0030);
    run(16'hF000, 3'b000, 16'h0);
    check("hlt_set", {15'b0, hlt}, 16'h0001);
    check("hlt_pc", pc, 16'h0030);
    for (int k = 0; k < 10; k++) begin
      apply(1'b0, 1'($urandom), 16'($urandom), 3'($urandom), 16'($urandom));
      tick();
      check("halted_pc", pc, 16'h0030);
      check("halted_hlt", {15'b0, hlt}, 16'h0001);
    end

    // Reset out of HALTED.
    apply(1'b1, 1'b0, 16'hF000, 3'b111, 16'h0);
    tick();
    check("rst_halt_pc", pc, 16'h0000);
    check("rst_halt_hlt", {15'b0, hlt}, 16'h0000);
    run(16'h3000, 3'b000, 16'h0);  check("rst_run_pc", pc, 16'h0002);

    // Stalled ADD holds, then completes.
    for (int k = 0; k < 3; k++) begin
      apply(1'b0, 1'b1, 16'h0000, 3'b111, 16'h0);
      tick();
      check("stall_pc", pc, 16'h0002);
      check("stall_flags", {13'b0, flags}, 16'h0000);
    end
    run(16'h0000, 3'b111, 16'h0);
    check("unstall_flags", {13'b0, flags}, 16'h0007);
    check("unstall_pc", pc, 16'h0004);

    // Reset wins over stall and HLT.
    apply(1'b1, 1'b1, 16'hF000, 3'b111, 16'h0);
    tick();
    check("rst_stall_pc", pc, 16'h0000);
    check("rst_stall_flags", {13'b0, flags}, 16'h0000);
    check("rst_stall_hlt", {15'b0, hlt}, 16'h0000);
    run(16'h3000, 3'b000, 16'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
